// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data RAM, LED framebuffer and MMIO registers on the core's load/store port,
// plus a row scan-out FSM feeding a serial LED-matrix driver. Define SHADOW_FB_EN for a double-buffered framebuffer.
module data_mem_mmio #(
   parameter int unsigned RAM_WORDS   = 1024,
   parameter int unsigned FB_ROWS     = 16,
   parameter int unsigned HOLD_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_write,
   input  logic                       mem_byte,
   input  logic [31:0]                alu_result,
   input  logic [31:0]                write_data,
   output logic [31:0]                read_data,
   output logic [$clog2(FB_ROWS)-1:0] led_row,
   output logic                       led_sdat,
   output logic                       led_sclk,
   output logic                       led_latch,
   output logic                       led_oe_n
);

   localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
   localparam int unsigned ROW_W   = $clog2(FB_ROWS);
   localparam int unsigned CNT_MAX = (HOLD_CYCLES > 64) ? HOLD_CYCLES : 64;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

   // Address decode and write lane steering
   logic [3:0]        region;
   logic [9:0]        word_idx;
   logic [1:0]        lane;
   logic [RAM_AW-1:0] ram_idx;
   logic [ROW_W-1:0]  fb_idx;
   logic              ram_sel, fb_sel, reg_sel, ctrl_wr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              unused_bits;

   assign region      = alu_result[15:12];
   assign word_idx    = alu_result[11:2];
   assign lane        = alu_result[1:0];
   assign ram_idx     = RAM_AW'(32'(word_idx) % RAM_WORDS);
   assign fb_idx      = ROW_W'(word_idx);
   assign ram_sel     = (region == 4'h0) || (region == 4'h1);
   assign fb_sel      = (region == 4'h2) && (32'(word_idx) < FB_ROWS);
   assign reg_sel     = (region == 4'h3);
   assign be          = mem_byte ? (4'b0001 << lane) : 4'b1111;
   assign wdata       = mem_byte ? {4{write_data[7:0]}} : write_data;
   assign ctrl_wr     = mem_write && reg_sel && (word_idx == 10'd1) && be[0];
   assign unused_bits = ^alu_result[31:16];

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [ROW_W-1:0]   row_d;
   logic [31:0]        sh_q, sh_d;
   logic               sdat_d, sclk_d, latch_d, oe_n_d, frame_inc;
   logic [31:0]        cycle_cnt, frame_cnt, ctrl_word;
   logic               scan_en;
   logic [31:0]        fb_cpu_word, fb_scan_word;

   logic [31:0] ram [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (mem_write && ram_sel)
         for (int i = 0; i < 4; i++)
            if (be[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
   end

`ifdef SHADOW_FB_EN
   // CPU owns the back bank, the scan reads the front bank
   logic [31:0] fb [2][FB_ROWS];
   logic        front, swap_pend, swap_c;

   assign fb_cpu_word  = fb[~front][fb_idx];
   assign fb_scan_word = fb[front][led_row];
   assign swap_c       = swap_pend && ((state == S_IDLE) || frame_inc);
   assign ctrl_word    = {30'b0, swap_pend, scan_en};

   always_ff @(posedge clk) begin
      if (mem_write && fb_sel)
         for (int i = 0; i < 4; i++)
            if (be[i]) fb[~front][fb_idx][8*i +: 8] <= wdata[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         front     <= 1'b0;
         swap_pend <= 1'b0;
      end else begin
         if (swap_c) front <= ~front;
         if (ctrl_wr && wdata[1]) swap_pend <= 1'b1;
         else if (swap_c)         swap_pend <= 1'b0;
      end
   end
`else
   logic [31:0] fb [FB_ROWS];

   assign fb_cpu_word  = fb[fb_idx];
   assign fb_scan_word = fb[led_row];
   assign ctrl_word    = {31'b0, scan_en};

   always_ff @(posedge clk) begin
      if (mem_write && fb_sel)
         for (int i = 0; i < 4; i++)
            if (be[i]) fb[fb_idx][8*i +: 8] <= wdata[8*i +: 8];
   end
`endif

   // Control and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         frame_cnt <= '0;
         scan_en   <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (frame_inc) frame_cnt <= frame_cnt + 32'd1;
         if (ctrl_wr)   scan_en   <= wdata[0];
      end
   end

   // Zero-latency load path
   logic [31:0] rword;
   always_comb begin
      rword = '0;
      if (ram_sel) begin
         rword = ram[ram_idx];
      end else if (fb_sel) begin
         rword = fb_cpu_word;
      end else if (reg_sel) begin
         case (word_idx)
            10'd0:   rword = cycle_cnt;
            10'd1:   rword = ctrl_word;
            10'd2:   rword = frame_cnt;
            default: rword = '0;
         endcase
      end
   end

   assign read_data = mem_byte ? {24'b0, rword[{lane, 3'b000} +: 8]} : rword;

   // Scan FSM state and registered LED outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sh_q      <= '0;
         led_row   <= '0;
         led_sdat  <= 1'b0;
         led_sclk  <= 1'b0;
         led_latch <= 1'b0;
         led_oe_n  <= 1'b1;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         sh_q      <= sh_d;
         led_row   <= row_d;
         led_sdat  <= sdat_d;
         led_sclk  <= sclk_d;
         led_latch <= latch_d;
         led_oe_n  <= oe_n_d;
      end
   end

   // Next state; LED outputs are derived from the next state so they are registered
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      row_d     = led_row;
      sh_d      = sh_q;
      frame_inc = 1'b0;
      case (state)
         S_IDLE: begin
            if (scan_en) begin
               state_d = S_LOAD;
               row_d   = '0;
            end
         end
         S_LOAD: begin
            sh_d    = fb_scan_word;
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == CNT_W'(63)) begin
               cnt_d   = '0;
               state_d = S_LATCH;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_LATCH: begin
            cnt_d   = '0;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               cnt_d = '0;
               if (led_row == ROW_W'(FB_ROWS - 1)) begin
                  row_d     = '0;
                  frame_inc = 1'b1;
               end else begin
                  row_d = led_row + ROW_W'(1);
               end
               state_d = scan_en ? S_LOAD : S_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      sdat_d  = (state_d == S_SHIFT) ? sh_d[~cnt_d[5:1]] : 1'b0;
      sclk_d  = (state_d == S_SHIFT) && cnt_d[0];
      latch_d = (state_d == S_LATCH);
      oe_n_d  = (state_d != S_HOLD);
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio: load/store decode, MMIO registers,
// scan-out timing with a short hold, frame wrap, enable drop mid-row and reset mid-shift.
module tb_data_mem_mmio;

   localparam int unsigned HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic        mem_byte;
   logic [31:0] alu_result;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [3:0]  led_row;
   logic        led_sdat, led_sclk, led_latch, led_oe_n;

   always #5 clk = ~clk;

   data_mem_mmio #(.RAM_WORDS(1024), .FB_ROWS(16), .HOLD_CYCLES(HOLD)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_write  (mem_write),
      .mem_byte   (mem_byte),
      .alu_result (alu_result),
      .write_data (write_data),
      .read_data  (read_data),
      .led_row    (led_row),
      .led_sdat   (led_sdat),
      .led_sclk   (led_sclk),
      .led_latch  (led_latch),
      .led_oe_n   (led_oe_n)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          k = 0;
   int          n_rise, n_latch, n_oe, first_latch, first_oe;
   logic        prev_sclk = 1'b0;
   logic [31:0] sh = '0;
   logic [31:0] lat_word = '0;
   logic [3:0]  lat_row = '0;
   logic [31:0] tb_cyc = '0;
   logic [31:0] v;

   // Expected CYCLE value: counts posedges since the last reset edge
   always @(posedge clk) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_rise = 0; n_latch = 0; n_oe = 0; first_latch = -1; first_oe = -1;
   endtask

   // Advance one cycle and deserialize the LED stream the way the matrix driver would
   task automatic step();
      @(negedge clk);
      k++;
      if (led_sclk && !prev_sclk) begin
         sh = {sh[30:0], led_sdat};
         n_rise++;
      end
      if (led_latch) begin
         lat_word = sh;
         lat_row  = led_row;
         n_latch++;
         if (first_latch < 0) first_latch = k;
      end
      if (!led_oe_n) begin
         n_oe++;
         if (first_oe < 0) first_oe = k;
      end
      prev_sclk = led_sclk;
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic bsz);
      alu_result = addr; write_data = data; mem_byte = bsz; mem_write = 1'b1;
      step();
      mem_write = 1'b0; mem_byte = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, input logic bsz, output logic [31:0] data);
      mem_write = 1'b0; mem_byte = bsz; alu_result = addr;
      #1;
      data = read_data;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mem_write = 1'b0; mem_byte = 1'b0; alu_result = '0; write_data = '0;
      clear_mon();
      repeat (3) step();
      reset = 1'b0;

      // Reset state
      check("rst_oe_n",  32'(led_oe_n), 32'd1);
      check("rst_sclk",  32'(led_sclk), 32'd0);
      check("rst_latch", 32'(led_latch), 32'd0);
      check("rst_sdat",  32'(led_sdat), 32'd0);
      check("rst_row",   32'(led_row), 32'd0);
      rd(32'h3004, 1'b0, v); check("rst_ctrl", v, 32'd0);
      rd(32'h3008, 1'b0, v); check("rst_frame", v, 32'd0);
      rd(32'h3000, 1'b0, v); check("rst_cycle", v, 32'd0);
      step();

      // Word / byte access
      wr(32'h10, 32'hA1B2C3D4, 1'b0);
      rd(32'h10, 1'b0, v); check("lw_10", v, 32'hA1B2C3D4);
      rd(32'h11, 1'b1, v); check("lbu_11", v, 32'h0000_00C3);
      wr(32'h13, 32'h0000_005E, 1'b1);
      rd(32'h10, 1'b0, v); check("sb_13", v, 32'h5EB2C3D4);
      rd(32'h12, 1'b1, v); check("lbu_12", v, 32'h0000_00B2);
      rd(32'h1010, 1'b0, v); check("ram_alias", v, 32'h5EB2C3D4);
      wr(32'h20, 32'h1111_2222, 1'b0);
      alu_result = 32'h20; write_data = 32'h3333_4444; mem_byte = 1'b0; mem_write = 1'b1;
      #1; check("rd_during_wr", read_data, 32'h1111_2222);
      step(); mem_write = 1'b0;
      rd(32'h20, 1'b0, v); check("wr_commit", v, 32'h3333_4444);

      // Unmapped and read-only
      rd(32'h4000, 1'b0, v); check("unmapped", v, 32'd0);
      wr(32'h3000, 32'hFFFF_FFFF, 1'b0);
      rd(32'h3000, 1'b0, v); check("cycle_ro", v, tb_cyc);
      wr(32'h3008, 32'h0000_00AB, 1'b0);
      rd(32'h3008, 1'b0, v); check("frame_ro", v, 32'd0);

      // Framebuffer contents and the row-16 boundary
      for (int r = 0; r < 16; r++)
         wr(32'h2000 + 32'(4 * r), (r == 0) ? 32'h8000_0001 : 32'h0, 1'b0);
      wr(32'h2040, 32'h1234_5678, 1'b0);
      rd(32'h2040, 1'b0, v); check("fb_row16", v, 32'd0);
      rd(32'h2000, 1'b0, v); check("fb_row0", v, 32'h8000_0001);
      rd(32'h2003, 1'b1, v); check("fb_byte", v, 32'h0000_0080);
      wr(32'h203C, 32'h0F0F_0F0F, 1'b0);
      rd(32'h203C, 1'b0, v); check("fb_row15", v, 32'h0F0F_0F0F);
      // Swap request: immediate in IDLE when shadowed, ignored otherwise
      wr(32'h3004, 32'h2, 1'b0);
      step();
      rd(32'h3004, 1'b0, v); check("ctrl_bit1", v, 32'd0);
      step();

      // Scan timing of row 0
      wr(32'h3004, 32'h1, 1'b0);
      k = 0; clear_mon();
      run_to(70);
      check("sclk_rises", 32'(n_rise), 32'd32);
      check("row0_bits", lat_word, 32'h8000_0001);
      check("latch_cnt", 32'(n_latch), 32'd1);
      check("latch_at", 32'(first_latch), 32'd66);
      check("oe_cycles", 32'(n_oe), 32'd4);
      check("oe_at", 32'(first_oe), 32'd67);
      check("row_at70", 32'(led_row), 32'd0);
      step();
      check("row_at71", 32'(led_row), 32'd1);

`ifdef SHADOW_FB_EN
      run_to(100);
      wr(32'h2014, 32'hFFFF_FFFF, 1'b0);
      wr(32'h3004, 32'h3, 1'b0);
      rd(32'h3004, 1'b0, v); check("swap_pending", v, 32'h3);
`endif

      run_to(420);
      check("row5_row", 32'(lat_row), 32'd5);
      check("row5_old", lat_word, 32'd0);

      // Frame wrap
      run_to(1120);
      check("pre_wrap_row", 32'(led_row), 32'd15);
      rd(32'h3008, 1'b0, v); check("pre_wrap_frame", v, 32'd0);
      step();
      check("wrap_row", 32'(led_row), 32'd0);
      rd(32'h3008, 1'b0, v); check("wrap_frame", v, 32'd1);
      check("latch_per_frame", 32'(n_latch), 32'd16);
`ifdef SHADOW_FB_EN
      rd(32'h3004, 1'b0, v); check("swap_done", v, 32'h1);
`endif

      run_to(1540);
      check("f2_row5_row", 32'(lat_row), 32'd5);
`ifdef SHADOW_FB_EN
      check("f2_row5_new", lat_word, 32'hFFFF_FFFF);
`else
      check("f2_row5", lat_word, 32'd0);
`endif

      // Dropping enable mid-row finishes the row, then idles
      run_to(1560);
      wr(32'h3004, 32'h0, 1'b0);
      run_to(1606);
      check("dis_latch", 32'(led_latch), 32'd1);
      run_to(1610);
      check("dis_hold", 32'(led_oe_n), 32'd0);
      check("dis_row6", 32'(led_row), 32'd6);
      step();
      check("dis_idle_oe", 32'(led_oe_n), 32'd1);
      check("dis_row7", 32'(led_row), 32'd7);
      clear_mon();
      run_to(1660);
      check("idle_quiet", 32'(n_rise + n_oe + n_latch), 32'd0);

      // Reset mid-SHIFT
      wr(32'h3004, 32'h1, 1'b0);
      k = 0;
      run_to(21);
      check("pre_rst_sclk", 32'(led_sclk), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mrst_oe_n",  32'(led_oe_n), 32'd1);
      check("mrst_sclk",  32'(led_sclk), 32'd0);
      check("mrst_sdat",  32'(led_sdat), 32'd0);
      check("mrst_latch", 32'(led_latch), 32'd0);
      check("mrst_row",   32'(led_row), 32'd0);
      rd(32'h3004, 1'b0, v); check("mrst_ctrl", v, 32'd0);
      rd(32'h3008, 1'b0, v); check("mrst_frame", v, 32'd0);
      rd(32'h10, 1'b0, v);   check("mrst_ram", v, 32'h5EB2C3D4);
      clear_mon();
      repeat (100) step();
      check("mrst_idle", 32'(n_rise + n_oe + n_latch), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
